// File: rtl/execute_muldiv.sv
// RV32 execute stage: ALU, operand forwarding, branch/jump resolution and an
// RV32M unit (multi-cycle multiplier, iterative restoring divider) that stalls the pipe.

module execute_muldiv_alu #(
    parameter int W = 32
) (
    input  logic [3:0]   ctrl,
    input  logic [2:0]   funct3,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] res,
    output logic         eq
);
    localparam int SW = $clog2(W);

    logic [SW-1:0] sh;
    logic          lt;
    logic          ltu;

    assign sh  = b[SW-1:0];
    assign lt  = $signed(a) < $signed(b);
    assign ltu = a < b;

    always_comb begin
        res = '0;
        case (ctrl)
            4'd0:    res = a + b;
            4'd1:    res = a - b;
            4'd2:    res = a & b;
            4'd3:    res = a | b;
            4'd4:    res = a ^ b;
            4'd5:    res = {{(W-1){1'b0}}, lt};
            4'd6:    res = {{(W-1){1'b0}}, ltu};
            4'd7:    res = a << sh;
            4'd8:    res = a >> sh;
            4'd9:    res = W'($signed(a) >>> sh);
            default: res = '0;
        endcase
    end

    // eq is the "branch condition holds" flag for the compare type in funct3
    always_comb begin
        eq = 1'b0;
        case (funct3)
            3'b000:  eq = (a == b);
            3'b001:  eq = (a != b);
            3'b100:  eq = lt;
            3'b101:  eq = ~lt;
            3'b110:  eq = ltu;
            3'b111:  eq = ~ltu;
            default: eq = 1'b0;
        endcase
    end
endmodule

module execute_muldiv #(
    parameter int D_WIDTH = 32,
    parameter int MUL_LAT = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         alu_ctrl_e,
    input  logic               alu_src_e,
    input  logic [D_WIDTH-1:0] rd1_e,
    input  logic [D_WIDTH-1:0] rd2_e,
    input  logic [D_WIDTH-1:0] pc_e,
    input  logic [D_WIDTH-1:0] imm_ext_e,
    input  logic               branch_e,
    input  logic               jump_e,
    input  logic               jalr_e,
    input  logic [2:0]         funct3_e,
    input  logic               muldiv_e,
    input  logic [D_WIDTH-1:0] result_w,
    input  logic [D_WIDTH-1:0] alu_result_m,
    input  logic [1:0]         fwd_rs1,
    input  logic [1:0]         fwd_rs2,
    output logic [D_WIDTH-1:0] alu_result_e,
    output logic [D_WIDTH-1:0] write_data_e,
    output logic [D_WIDTH-1:0] pc_target_e,
    output logic               pc_src_e,
    output logic               stall_e
);
    localparam int CW = $clog2(D_WIDTH + MUL_LAT + 1);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [D_WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [2:0]         f3_q, f3_d;
    logic [D_WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, res_q, res_d;

    logic [D_WIDTH-1:0] src_a, fwd_b, src_b, res;
    logic               eq;

    always_comb begin
        case (fwd_rs1)
            2'b00:   src_a = rd1_e;
            2'b01:   src_a = result_w;
            2'b10:   src_a = alu_result_m;
            default: src_a = '0;
        endcase
        case (fwd_rs2)
            2'b00:   fwd_b = rd2_e;
            2'b01:   fwd_b = result_w;
            2'b10:   fwd_b = alu_result_m;
            default: fwd_b = '0;
        endcase
    end

    assign src_b        = alu_src_e ? imm_ext_e : fwd_b;
    assign write_data_e = fwd_b;

    execute_muldiv_alu #(.W(D_WIDTH)) u_alu (
        .ctrl   (alu_ctrl_e),
        .funct3 (funct3_e),
        .a      (src_a),
        .b      (src_b),
        .res    (res),
        .eq     (eq)
    );

    assign pc_target_e = jalr_e ? res : pc_e + imm_ext_e;
    assign pc_src_e    = jump_e | (branch_e & eq);

    // Multiplier: operands sign- or zero-extended to 2*D_WIDTH per M-op flavour
    logic                 a_sext, b_sext;
    logic [2*D_WIDTH-1:0] ext_a, ext_b, prod;

    assign a_sext = (f3_q[1:0] == 2'b01) || (f3_q[1:0] == 2'b10);
    assign b_sext = (f3_q[1:0] == 2'b01);
    assign ext_a  = {{D_WIDTH{a_sext & op_a_q[D_WIDTH-1]}}, op_a_q};
    assign ext_b  = {{D_WIDTH{b_sext & op_b_q[D_WIDTH-1]}}, op_b_q};
    assign prod   = ext_a * ext_b;

    // Divider works on magnitudes; even funct3[0] means a signed op
    logic               a_neg, b_neg, div0, ovf, ge;
    logic [D_WIDTH-1:0] abs_a, abs_b, quo_cur, rem_cur, quo_nx, rem_nx, q_fin, r_fin;
    logic [D_WIDTH:0]   shifted, diff;

    assign a_neg   = ~f3_q[0] & op_a_q[D_WIDTH-1];
    assign b_neg   = ~f3_q[0] & op_b_q[D_WIDTH-1];
    assign abs_a   = a_neg ? -op_a_q : op_a_q;
    assign abs_b   = b_neg ? -op_b_q : op_b_q;
    assign div0    = (op_b_q == '0);
    assign ovf     = ~f3_q[0] && (op_a_q == {1'b1, {(D_WIDTH-1){1'b0}}}) && (op_b_q == '1);
    // first iteration seeds the working dividend directly from the latched operand
    assign quo_cur = (cnt_q == '0) ? abs_a : quo_q;
    assign rem_cur = (cnt_q == '0) ? '0 : rem_q;
    assign shifted = {rem_cur, quo_cur[D_WIDTH-1]};
    assign diff    = shifted - {1'b0, abs_b};
    assign ge      = shifted >= {1'b0, abs_b};
    assign rem_nx  = ge ? diff[D_WIDTH-1:0] : shifted[D_WIDTH-1:0];
    assign quo_nx  = {quo_cur[D_WIDTH-2:0], ge};
    assign q_fin   = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
    assign r_fin   = a_neg ? -rem_nx : rem_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            f3_q    <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            f3_q    <= f3_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        f3_d    = f3_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (muldiv_e) begin
                    op_a_d  = src_a;
                    op_b_d  = fwd_b;
                    f3_d    = funct3_e;
                    state_d = funct3_e[2] ? S_DIV : S_MUL;
                end
            end
            S_MUL: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(MUL_LAT - 1)) begin
                    res_d   = (f3_q[1:0] == 2'b00) ? prod[D_WIDTH-1:0] : prod[2*D_WIDTH-1:D_WIDTH];
                    state_d = S_DONE;
                end
            end
            S_DIV: begin
                if (div0 || ovf) begin
                    if (f3_q[1]) res_d = div0 ? op_a_q : '0;
                    else         res_d = div0 ? '1 : op_a_q;
                    state_d = S_DONE;
                end else begin
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(D_WIDTH - 1)) begin
                        res_d   = f3_q[1] ? r_fin : q_fin;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        stall_e      = 1'b0;
        alu_result_e = res;
        case (state_q)
            S_IDLE:  stall_e = muldiv_e;
            S_MUL:   stall_e = 1'b1;
            S_DIV:   stall_e = 1'b1;
            default: alu_result_e = res_q;
        endcase
    end
endmodule

// File: tb/tb_execute_muldiv.sv
// Randomised self-checking bench for execute_muldiv against an arithmetic reference model.
module tb_execute_muldiv;
    localparam int D_WIDTH = 32;
    localparam int MUL_LAT = 2;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  alu_ctrl_e = '0;
    logic        alu_src_e = 1'b0;
    logic [31:0] rd1_e = '0, rd2_e = '0, pc_e = '0, imm_ext_e = '0;
    logic        branch_e = 1'b0, jump_e = 1'b0, jalr_e = 1'b0;
    logic [2:0]  funct3_e = '0;
    logic        muldiv_e = 1'b0;
    logic [31:0] result_w = '0, alu_result_m = '0;
    logic [1:0]  fwd_rs1 = '0, fwd_rs2 = '0;
    logic [31:0] alu_result_e, write_data_e, pc_target_e;
    logic        pc_src_e, stall_e;

    int tests = 0;
    int fails = 0;

    execute_muldiv #(.D_WIDTH(D_WIDTH), .MUL_LAT(MUL_LAT)) dut (
        .clk(clk), .rst(rst), .alu_ctrl_e(alu_ctrl_e), .alu_src_e(alu_src_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .pc_e(pc_e), .imm_ext_e(imm_ext_e),
        .branch_e(branch_e), .jump_e(jump_e), .jalr_e(jalr_e), .funct3_e(funct3_e),
        .muldiv_e(muldiv_e), .result_w(result_w), .alu_result_m(alu_result_m),
        .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2), .alu_result_e(alu_result_e),
        .write_data_e(write_data_e), .pc_target_e(pc_target_e), .pc_src_e(pc_src_e),
        .stall_e(stall_e)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_md(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f3)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN && b == 32'hFFFF_FFFF) return MIN;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == MIN && b == 32'hFFFF_FFFF) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_stalls(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return MUL_LAT + 1;
        if (b == 0 || (!f3[0] && a == MIN && b == 32'hFFFF_FFFF)) return 2;
        return D_WIDTH + 1;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            default: return $signed(a) >>> b[4:0];
        endcase
    endfunction

    function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000: return a == b;
            3'b001: return a != b;
            3'b100: return $signed(a) < $signed(b);
            3'b101: return $signed(a) >= $signed(b);
            3'b110: return a < b;
            3'b111: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one M-op from its IDLE cycle through DONE, scrambling forwarding sources during the stall.
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fr1, input string name);
        logic [31:0] exp_res;
        int          exp_st, stalls;
        bit          done;
        exp_res = ref_md(f3, a, b);
        exp_st  = ref_stalls(f3, a, b);
        muldiv_e = 1'b1; funct3_e = f3; alu_src_e = 1'b0; fwd_rs1 = fr1; fwd_rs2 = 2'b00;
        branch_e = 1'b0; jump_e = 1'b0; jalr_e = 1'b0;
        rd1_e = $urandom; result_w = $urandom; alu_result_m = $urandom;
        case (fr1)
            2'b01:   result_w = a;
            2'b10:   alu_result_m = a;
            default: rd1_e = a;
        endcase
        rd2_e  = b;
        stalls = 0;
        done   = 1'b0;
        for (int c = 0; c < 100 && !done; c++) begin
            #2;
            if (stall_e) begin
                stalls++;
                @(posedge clk); #1;
                rd1_e = $urandom; rd2_e = $urandom; result_w = $urandom; alu_result_m = $urandom;
            end else begin
                done = 1'b1;
            end
        end
        tests++;
        if (!done) begin
            fails++; $display("FAIL %s timeout: stall_e never dropped", name);
        end
        tests++;
        if (stalls !== exp_st) begin
            fails++; $display("FAIL %s stall cycles: got %0d expected %0d", name, stalls, exp_st);
        end
        tests++;
        if (alu_result_e !== exp_res) begin
            fails++; $display("FAIL %s result: got %h expected %h", name, alu_result_e, exp_res);
        end
        @(posedge clk); #1;
        muldiv_e = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; muldiv_e = 1'b0; alu_ctrl_e = 4'd0; fwd_rs1 = 2'b00; fwd_rs2 = 2'b00;
        rd1_e = 32'd1; rd2_e = 32'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #2;
        tests++;
        if (stall_e !== 1'b0) begin fails++; $display("FAIL reset stall: got %b expected 0", stall_e); end
        tests++;
        if (alu_result_e !== 32'd3) begin fails++; $display("FAIL reset alu: got %h expected 3", alu_result_e); end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [31:0] a, b, sa, fb;
        alu_ctrl_e = 4'd0; alu_src_e = 1'b0; fwd_rs1 = 2'b10; fwd_rs2 = 2'b00;
        alu_result_m = 32'd5; rd2_e = 32'd7; muldiv_e = 1'b0;
        #2;
        tests++;
        if (alu_result_e !== 32'd12 || stall_e !== 1'b0 || write_data_e !== 32'd7) begin
            fails++; $display("FAIL alu_fwd_add: res %0d stall %b wd %0d expected 12 0 7",
                              alu_result_e, stall_e, write_data_e);
        end
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            alu_ctrl_e = 4'($urandom_range(0, 9)); alu_src_e = 1'($urandom);
            fwd_rs1 = 2'($urandom); fwd_rs2 = 2'($urandom);
            rd1_e = $urandom; rd2_e = $urandom; result_w = $urandom; alu_result_m = $urandom;
            imm_ext_e = $urandom;
            sa = (fwd_rs1 == 0) ? rd1_e : (fwd_rs1 == 1) ? result_w : (fwd_rs1 == 2) ? alu_result_m : 32'd0;
            fb = (fwd_rs2 == 0) ? rd2_e : (fwd_rs2 == 1) ? result_w : (fwd_rs2 == 2) ? alu_result_m : 32'd0;
            a = sa; b = alu_src_e ? imm_ext_e : fb;
            #2;
            tests++;
            if (alu_result_e !== ref_alu(alu_ctrl_e, a, b) || write_data_e !== fb) begin
                fails++; $display("FAIL alu_rand op%0d: res %h wd %h expected %h %h",
                                  alu_ctrl_e, alu_result_e, write_data_e, ref_alu(alu_ctrl_e, a, b), fb);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_branch();
        logic [2:0] f3s [6];
        f3s = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
        fwd_rs1 = 2'b00; fwd_rs2 = 2'b00; alu_src_e = 1'b0; alu_ctrl_e = 4'd1;
        branch_e = 1'b1; jump_e = 1'b0; jalr_e = 1'b0; funct3_e = 3'b000;
        rd1_e = 32'd3; rd2_e = 32'd3; pc_e = 32'h100; imm_ext_e = 32'h20;
        #2;
        tests++;
        if (pc_src_e !== 1'b1 || pc_target_e !== 32'h120) begin
            fails++; $display("FAIL beq: src %b tgt %h expected 1 120", pc_src_e, pc_target_e);
        end
        @(posedge clk); #1;
        branch_e = 1'b0; jump_e = 1'b1; jalr_e = 1'b1; alu_ctrl_e = 4'd0; alu_src_e = 1'b1;
        rd1_e = 32'h200; imm_ext_e = 32'd4;
        #2;
        tests++;
        if (pc_src_e !== 1'b1 || pc_target_e !== 32'h204) begin
            fails++; $display("FAIL jalr: src %b tgt %h expected 1 204", pc_src_e, pc_target_e);
        end
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            branch_e = 1'b1; jump_e = 1'b0; jalr_e = 1'b0; alu_src_e = 1'b0; alu_ctrl_e = 4'd1;
            funct3_e = f3s[i % 6];
            rd1_e = $urandom; rd2_e = (i % 3 == 0) ? rd1_e : $urandom;
            pc_e = $urandom; imm_ext_e = $urandom;
            #2;
            tests++;
            if (pc_src_e !== ref_taken(funct3_e, rd1_e, rd2_e) || pc_target_e !== pc_e + imm_ext_e) begin
                fails++; $display("FAIL branch f3=%0d: src %b tgt %h expected %b %h", funct3_e,
                                  pc_src_e, pc_target_e, ref_taken(funct3_e, rd1_e, rd2_e), pc_e + imm_ext_e);
            end
        end
        @(posedge clk); #1;
        branch_e = 1'b0;
    endtask

    task automatic test_mul();
        run_mop(3'd1, MIN, MIN, 2'b00, "mulh_min");
        run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, "mulhu_max");
        for (int i = 0; i < 12; i++)
            run_mop(3'($urandom_range(0, 3)), $urandom, $urandom, 2'($urandom_range(0, 2)), "mul_rand");
    endtask

    task automatic test_div();
        run_mop(3'd4, -32'sd7, 32'd2, 2'b00, "div_neg7_2");
        run_mop(3'd6, -32'sd7, 32'd2, 2'b00, "rem_neg7_2");
        run_mop(3'd5, 32'd7, 32'd0, 2'b00, "divu_by0");
        run_mop(3'd6, MIN, 32'hFFFF_FFFF, 2'b00, "rem_ovf");
        run_mop(3'd4, MIN, 32'hFFFF_FFFF, 2'b00, "div_ovf");
        run_mop(3'd7, 32'd9, 32'd0, 2'b00, "remu_by0");
        for (int i = 0; i < 12; i++)
            run_mop(3'($urandom_range(4, 7)), $urandom,
                    (i % 2 == 0) ? 32'($signed(16'($urandom))) : $urandom, 2'b00, "div_rand");
    endtask

    task automatic test_capture();
        run_mop(3'd4, 32'd1000, 32'd7, 2'b01, "div_capture_w");
        run_mop(3'd0, 32'd123, 32'd45, 2'b10, "mul_capture_m");
    endtask

    task automatic test_back_to_back();
        run_mop(3'd0, 32'd3, 32'd5, 2'b00, "b2b_mul");
        run_mop(3'd5, 32'd100, 32'd9, 2'b00, "b2b_divu");
        run_mop(3'd2, 32'hFFFF_FFFE, 32'd3, 2'b00, "b2b_mulhsu");
    endtask

    task automatic test_reset_mid();
        muldiv_e = 1'b1; funct3_e = 3'd4; fwd_rs1 = 2'b00; fwd_rs2 = 2'b00; alu_src_e = 1'b0;
        rd1_e = 32'd1000; rd2_e = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
        end
        #1;
        tests++;
        if (stall_e !== 1'b1) begin fails++; $display("FAIL rst_mid pre: stall %b expected 1", stall_e); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; muldiv_e = 1'b0; alu_ctrl_e = 4'd0; rd1_e = 32'd10; rd2_e = 32'd20;
        #1;
        tests++;
        if (stall_e !== 1'b0 || alu_result_e !== 32'd30) begin
            fails++; $display("FAIL rst_mid post: stall %b res %h expected 0 1e", stall_e, alu_result_e);
        end
        @(posedge clk); #1;
        run_mop(3'd0, 32'd6, 32'd7, 2'b00, "mul_after_rst");
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_mul();
        test_div();
        test_capture();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/execute_muldiv.md
Name: execute_muldiv

Overview:
- Next-generation execute stage for the 5-stage RV32 pipeline.
- Keeps ALU execution, operand forwarding and branch/jump target resolution.
- Adds the RV32M extension: a multi-cycle multiplier with configurable latency and an iterative radix-2 divider.
- While an M-op is in flight it raises a stall to the hazard unit, which freezes F/D/E and bubbles M.

Parameters:
D_WIDTH, 32, datapath width; must be even and >= 8.
MUL_LAT, 2, cycles spent in state MUL; must be >= 1.

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
alu_ctrl_e  input  4  ALU operation select
alu_src_e  input  1  0: operand B = forwarded rs2; 1: imm_ext_e
rd1_e  input  D_WIDTH  register-file rs1 value
rd2_e  input  D_WIDTH  register-file rs2 value
pc_e  input  D_WIDTH  PC of the E-stage instruction
imm_ext_e  input  D_WIDTH  sign-extended immediate
branch_e  input  1  instruction is a conditional branch
jump_e  input  1  instruction is JAL/JALR
jalr_e  input  1  target = ALU result (JALR)
funct3_e  input  3  ALU compare type; M-op select when muldiv_e=1
muldiv_e  input  1  instruction is an RV32M op
result_w  input  D_WIDTH  W-stage forwarding value
alu_result_m  input  D_WIDTH  M-stage forwarding value
fwd_rs1  input  2  00 rd1_e, 01 result_w, 10 alu_result_m, 11 zero
fwd_rs2  input  2  same encoding for rs2
alu_result_e  output  D_WIDTH  ALU result, or M-op result in DONE
write_data_e  output  D_WIDTH  forwarded rs2 (store data)
pc_target_e  output  D_WIDTH  branch/jump target
pc_src_e  output  1  redirect fetch
stall_e  output  1  M-op busy; hazard unit holds F/D/E and bubbles M

Behaviour:
- Combinational path:
  - src_a = fwd_rs1 mux; fwd_b = fwd_rs2 mux.
  - write_data_e = fwd_b.
  - src_b = alu_src_e ? imm_ext_e : fwd_b.
  - Existing alu instance produces res and eq.
  - pc_target_e = jalr_e ? res : pc_e + imm_ext_e.
  - pc_src_e = jump_e | (branch_e & eq).
- FSM states: IDLE, MUL, DIV, DONE. Reset → IDLE, cnt=0, op/result registers 0, stall_e=0.
- IDLE:
  - muldiv_e=0: stall_e=0, alu_result_e=res.
  - muldiv_e=1: stall_e=1. Latch src_a, fwd_b and funct3_e, because forwarded sources change during the stall.
  - funct3[2]=0 → MUL. funct3[2]=1 → DIV.
- MUL:
  - stall_e=1 for exactly MUL_LAT cycles, then → DONE.
  - Product is 2*D_WIDTH bits. Operands are extended as follows:
    - 000 MUL: low half.
    - 001 MULH: signed×signed, high half.
    - 010 MULHSU: signed×unsigned, high half.
    - 011 MULHU: unsigned×unsigned, high half.
- DIV:
  - Restoring division on operand magnitudes (signed ops: 100 DIV, 110 REM); unsigned magnitudes for 101 DIVU, 111 REMU.
  - One quotient bit per cycle for D_WIDTH cycles, then sign correction: quotient negated if signs differ; remainder takes the dividend sign. Then → DONE.
  - Special cases, resolved after 1 DIV cycle then → DONE:
    - Divisor 0: quotient = all ones, remainder = dividend.
    - Signed MIN / -1: quotient = MIN, remainder = 0.
- DONE:
  - stall_e=0, alu_result_e = latched M-op result. The pipeline advances at the clock edge.
  - Always → IDLE; no restart even though muldiv_e is still 1 in this cycle.
- Occupancy of E:
  - MUL ops: MUL_LAT+2 cycles, with stall_e high for MUL_LAT+1 of them.
  - DIV ops: D_WIDTH+2 cycles; special cases take 3.
- pc_src_e is combinational and unaffected by FSM state; M-ops never assert branch_e or jump_e.
- Back-to-back M-ops: the second starts in the IDLE cycle that follows DONE.
- rst mid-operation: next cycle is IDLE with stall_e=0; the partial result is discarded.

Test Plan:
- ADD with fwd_rs1=10, alu_result_m=5, rd2_e=7, alu_src_e=0 → alu_result_e=12, stall_e=0, write_data_e=7.
- BEQ, rd1=rd2=3, pc_e=0x100, imm=0x20 → pc_src_e=1, pc_target_e=0x120; JALR with rs1=0x200, imm=4 → pc_target_e=0x204.
- MULH with 0x80000000 × 0x80000000, MUL_LAT=2 → stall_e high for 3 cycles, DONE shows 0x40000000. MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
- DIV with -7/2 → stall_e high for 33 cycles, result 0xFFFFFFFD. REM with -7/2 → 0xFFFFFFFF. DIVU with 7/0 → 0xFFFFFFFF after 2 stall cycles. REM with 0x80000000/-1 → 0.
- Start DIV with fwd_rs1=01, then change result_w every stall cycle → result uses the value captured at start.
- Assert rst at DIV iteration 10 → stall_e=0 next cycle. A following MUL of 6×7 → 42 with correct MUL_LAT+1 stall cycles.
